// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: 34-cycle latency, 1 cycle for special cases.
// busy_o blocks new requests; defining DIV_EARLY_EXIT_EN resolves |dividend| < |divisor| in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sel_rem_q, sel_rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             valid_q, valid_d;

  logic             is_signed, is_rem, a_neg, b_neg;
  logic             div_zero, ovf, early_exit;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
  logic [WIDTH:0]   shifted, trial;

  assign is_signed = ~op_i[0];
  assign is_rem    = op_i[1];
  assign a_neg     = is_signed & dividend_i[WIDTH-1];
  assign b_neg     = is_signed & divisor_i[WIDTH-1];
  assign mag_a     = a_neg ? -dividend_i : dividend_i;
  assign mag_b     = b_neg ? -divisor_i : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign ovf       = is_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = (mag_a < mag_b);
`else
  assign early_exit = 1'b0;
`endif

  // Partial remainder stays below the divisor, so 33 bits hold the trial.
  assign shifted = {acc_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign q_fix   = qneg_q ? -quo_q : quo_q;
  assign r_fix   = rneg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    sel_rem_d = sel_rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !kill_i) begin
          sel_rem_d = is_rem;
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          if (div_zero) begin
            result_d = is_rem ? dividend_i : '1;
            valid_d  = 1'b1;
          end else if (ovf) begin
            result_d = is_rem ? '0 : MIN_NEG;
            valid_d  = 1'b1;
          end else if (early_exit) begin
            result_d = is_rem ? dividend_i : '0;
            valid_d  = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH - 1);
            acc_d   = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
          end
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          acc_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!kill_i) begin
          result_d = sel_rem_q ? r_fix : q_fix;
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      sel_rem_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      sel_rem_q <= sel_rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases plus randomized ops against an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        kill_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_res;

  localparam logic [31:0] MINV = 32'h8000_0000;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .kill_i(kill_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V semantics straight from the ISA rules, using native integer division.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        return sa / sb;
      end
      2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return 1;
    if (!op[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
    if (!op[0]) begin
      ma = (sa < 0) ? -longint'(sa) : longint'(sa);
      mb = (sb < 0) ? -longint'(sb) : longint'(sb);
    end else begin
      ma = longint'(a);
      mb = longint'(b);
    end
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) return 1;
`else
    if (ma < 0 || mb < 0) return 1;
`endif
    return 34;
  endfunction

  // Called at a negedge (cycle N); returns at the negedge of the valid cycle.
  // inj > 0 raises a stray start in cycle N+inj that must be ignored.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int inj);
    logic [31:0] exp;
    int elat, lat, bcnt;
    exp  = ref_result(o, a, b);
    elat = ref_lat(o, a, b);
    start_i = 1'b1; op_i = o; dividend_i = a; divisor_i = b;
    @(negedge clk);
    start_i = 1'b0;
    op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom;
    lat = 1;
    bcnt = 0;
    while (!valid_o && lat < 60) begin
      if (busy_o) bcnt++;
      start_i = (lat == inj);
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy_cyc"}, bcnt, elat - 1);
    chk({tag, "_busy_at_valid"}, {31'b0, busy_o}, 32'h0);
    chk({tag, "_res"}, result_o, exp);
    last_res = exp;
  endtask

  task automatic quiet_window(input string tag, input int cycles, input logic [31:0] exp_res);
    int vcnt;
    vcnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid_o) vcnt++;
    end
    chk({tag, "_no_valid"}, vcnt, 0);
    chk({tag, "_res_held"}, result_o, exp_res);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return MINV;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0;
    op_i = 2'd0; dividend_i = '0; divisor_i = '0;
    last_res = '0;
    #1;
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_result", result_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_m7_2_exact", result_o, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("rem_m7_2_exact", result_o, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("single_pulse", {31'b0, valid_o}, 32'h0);

    do_op("divu_by0", 2'd1, 32'd100, 32'd0, 0);
    do_op("remu_by0", 2'd3, 32'd100, 32'd0, 0);
    chk("remu_by0_exact", result_o, 32'h0000_0064);
    do_op("div_ovf", 2'd0, MINV, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf", 2'd2, MINV, 32'hFFFF_FFFF, 0);
    do_op("divu_ign", 2'd1, 32'hFFFF_FFFF, 32'h10, 10);
    chk("divu_ign_exact", result_o, 32'h0FFF_FFFF);

    // kill at N+15 of a DIV: aborts without a valid, result retained
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd0; dividend_i = 32'd1000; divisor_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_busy", {31'b0, busy_o}, 32'h0);
    quiet_window("kill", 40, last_res);

    // kill together with start in IDLE drops the request
    start_i = 1'b1; kill_i = 1'b1; op_i = 2'd1; dividend_i = 32'd9; divisor_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b0;
    chk("kill_start_busy", {31'b0, busy_o}, 32'h0);
    quiet_window("kill_start", 5, last_res);

    do_op("div_10_3", 2'd0, 32'd10, 32'd3, 0);
    chk("div_10_3_exact", result_o, 32'h3);
    do_op("rem_5_9", 2'd2, 32'd5, 32'd9, 0);
    chk("rem_5_9_exact", result_o, 32'h5);

    // asynchronous reset in the middle of a long operation
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd1; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
    chk("mid_rst_valid", {31'b0, valid_o}, 32'h0);
    chk("mid_rst_result", result_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("post_rst", 40, 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom);
      a = pick();
      b = pick();
      do_op("rnd", o, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
